rtc_ctrl: RTL and testbench
===========================

RTC_CTRL -- requirements
Module: rtc_ctrl

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 100, giving the number of i_basetick pulses per second (10 ms base tick); legal range 2..255.
REQ-002 The block SHALL have port i_sclk  input  1  system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_reset  input  1  synchronous reset, active-high.
REQ-004 The block SHALL have port i_basetick  input  1  one-cycle pulse from the RTC timer.
REQ-005 The block SHALL have port i_run  input  1  level; 1 = time-of-day counting requested.
REQ-006 The block SHALL have port i_set_req  input  1  one-cycle time-load request.
REQ-007 The block SHALL have ports i_set_hh / i_set_mm / i_set_ss  input  5/6/6  time value to load.
REQ-008 The block SHALL have port i_alarm_wr  input  1  one-cycle alarm-register write.
REQ-009 The block SHALL have ports i_alarm_hh / i_alarm_mm / i_alarm_ss  input  5/6/6  alarm value.
REQ-010 The block SHALL have port i_alarm_en  input  1  level; alarm compare enable.
REQ-011 The block SHALL have port i_irq_ack  input  1  one-cycle interrupt clear.
REQ-012 The block SHALL have port o_timerenb  output  1  enable to the RTC timer.
REQ-013 The block SHALL have ports o_hh / o_mm / o_ss  output  5/6/6  current time, registered.
REQ-014 The block SHALL have ports o_sec_pulse, o_set_ack, o_set_err  output  1 each  one-cycle pulses.
REQ-015 The block SHALL have port o_irq  output  1  sticky alarm interrupt.

Function
REQ-016 The FSM SHALL have states STOP, RUN and LOAD; o_timerenb SHALL be 1 only in RUN, decoded from the state register.
REQ-017 In STOP, when i_run=1 and i_set_req=0, the FSM SHALL enter RUN on the next edge.
REQ-018 In RUN, when i_run=0 and i_set_req=0, the FSM SHALL enter STOP on the next edge; the prescaler SHALL hold its value.
REQ-019 From any state, i_set_req=1 SHALL move the FSM to LOAD on the next edge and capture the i_set_* values; i_set_req SHALL take priority over i_run and i_basetick in that cycle.
REQ-020 LOAD SHALL last exactly one cycle and behave as follows:
- Captured value valid (hh<=23, mm<=59, ss<=59): write it to o_hh/o_mm/o_ss, clear the prescaler, pulse o_set_ack.
- Captured value invalid: leave time and prescaler unchanged, pulse o_set_err, do not assert o_set_ack.
- Exit: next state is RUN if i_run=1, else STOP.
REQ-021 In RUN, each i_basetick SHALL increment the prescaler; when a tick arrives with prescaler = TICKS_PER_SEC-1, the prescaler SHALL return to 0 and the time SHALL advance one second.
REQ-022 i_basetick SHALL be ignored in STOP and LOAD.
REQ-023 Time advance SHALL follow these rules:
- ss wraps 59->0 with carry into mm.
- mm wraps 59->0 with carry into hh.
- hh wraps 23->0.
- All digits update in the same cycle, so 23:59:59 becomes 00:00:00 in one edge.
REQ-024 o_sec_pulse SHALL be 1 for exactly the cycle after each second advance, aligned with the updated o_hh/o_mm/o_ss.
REQ-025 i_alarm_wr SHALL load the alarm registers on the next edge; values are not range-checked, and an out-of-range alarm never matches.
REQ-026 An alarm match event SHALL occur when all of the following hold:
- i_alarm_en = 1.
- A second advance or a valid LOAD produces a time equal to the alarm registers.
- On match, o_irq SHALL be set on the same edge as the time update.
REQ-027 o_irq SHALL stay 1 until the edge after i_irq_ack; when ack and a new match occur in the same cycle, set SHALL win.
REQ-028 A match SHALL be detected only on a time change; an unchanged time while STOPped SHALL NOT re-assert o_irq after it is acked.

Reset
REQ-029 With i_reset=1 at an edge, the block SHALL apply the following on that edge:
- FSM enters STOP.
- Prescaler cleared.
- o_hh/o_mm/o_ss cleared to 00:00:00.
- Alarm registers cleared.
- o_timerenb, o_sec_pulse, o_set_ack, o_set_err and o_irq driven to 0.
REQ-030 Reset SHALL override all inputs, including during LOAD and at a pending carry; operation SHALL resume from STOP on the first edge with i_reset=0.

Verification (TICKS_PER_SEC=4)
REQ-031 Reset, then i_run=1 and one i_basetick every 10 cycles for 40 cycles: o_timerenb=1 from cycle 1; o_sec_pulse fires after the 4th tick; time reads 00:00:01.
REQ-032 Set 23:59:59, run, apply 4 ticks: a single edge yields 00:00:00 with one o_sec_pulse.
REQ-033 Set 24:00:00 or 12:60:00: o_set_err pulses, o_set_ack stays 0, time is unchanged.
REQ-034 Alarm 00:00:02 with i_alarm_en=1, run 8 ticks: o_irq rises with the 00:00:02 update; i_irq_ack clears it; pulse i_irq_ack on the same cycle as a re-match (reload 00:00:01 and tick): o_irq stays 1.
REQ-035 Drop i_run to 0 after 2 ticks, tick 5 times, raise i_run, tick 2 more: exactly one second elapses, because the prescaler holds at 2 while stopped.
REQ-036 Assert i_reset during LOAD, and separately on the edge of a 00:59:59 carry: all outputs read zero, the FSM is in STOP, and no o_set_ack or o_sec_pulse is emitted.

Source files
------------

// File: rtl/rtc_ctrl_if.sv
// Host-side signal bundle for the time-of-day controller.
// The master side drives requests; the slave side (rtc_ctrl) returns time and status.
interface rtc_ctrl_if;
  logic       i_basetick;
  logic       i_run;
  logic       i_set_req;
  logic [4:0] i_set_hh;
  logic [5:0] i_set_mm;
  logic [5:0] i_set_ss;
  logic       i_alarm_wr;
  logic [4:0] i_alarm_hh;
  logic [5:0] i_alarm_mm;
  logic [5:0] i_alarm_ss;
  logic       i_alarm_en;
  logic       i_irq_ack;
  logic       o_timerenb;
  logic [4:0] o_hh;
  logic [5:0] o_mm;
  logic [5:0] o_ss;
  logic       o_sec_pulse;
  logic       o_set_ack;
  logic       o_set_err;
  logic       o_irq;

  modport master (
    output i_basetick, i_run, i_set_req, i_set_hh, i_set_mm, i_set_ss,
           i_alarm_wr, i_alarm_hh, i_alarm_mm, i_alarm_ss, i_alarm_en, i_irq_ack,
    input  o_timerenb, o_hh, o_mm, o_ss, o_sec_pulse, o_set_ack, o_set_err, o_irq
  );

  modport slave (
    input  i_basetick, i_run, i_set_req, i_set_hh, i_set_mm, i_set_ss,
           i_alarm_wr, i_alarm_hh, i_alarm_mm, i_alarm_ss, i_alarm_en, i_irq_ack,
    output o_timerenb, o_hh, o_mm, o_ss, o_sec_pulse, o_set_ack, o_set_err, o_irq
  );
endinterface

// File: rtl/rtc_ctrl.sv
// Real-time-clock controller: STOP/RUN/LOAD sequencing, base-tick prescaler,
// hh:mm:ss counter with validated time load and a sticky alarm interrupt.
module rtc_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       i_sclk,
  input  logic       i_reset,
  rtc_ctrl_if.slave  bus
);

  localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {STOP = 2'd0, RUN = 2'd1, LOAD = 2'd2} state_t;

  state_t     state_reg, state_next;
  logic [7:0] presc_reg, presc_next;
  logic [4:0] hh_reg, hh_next, inc_hh, cap_hh_reg, alm_hh_reg;
  logic [5:0] mm_reg, mm_next, inc_mm, cap_mm_reg, alm_mm_reg;
  logic [5:0] ss_reg, ss_next, inc_ss, cap_ss_reg, alm_ss_reg;
  logic       sec_pulse_reg, set_ack_reg, set_err_reg, irq_reg;
  logic       timerenb, cap_valid, tick_run, sec_adv, load_ok, load_bad, time_match;

  always_ff @(posedge i_sclk) begin
    if (i_reset) state_reg <= STOP;
    else         state_reg <= state_next;
  end

  // A set request preempts everything; otherwise i_run alone picks RUN or STOP.
  always_comb begin
    state_next = state_reg;
    if (bus.i_set_req) begin
      state_next = LOAD;
    end else begin
      case (state_reg)
        STOP:    if (bus.i_run)  state_next = RUN;
        RUN:     if (!bus.i_run) state_next = STOP;
        LOAD:    state_next = bus.i_run ? RUN : STOP;
        default: state_next = STOP;
      endcase
    end
  end

  always_comb begin
    timerenb  = (state_reg == RUN);
    cap_valid = (cap_hh_reg <= 5'd23) && (cap_mm_reg <= 6'd59) && (cap_ss_reg <= 6'd59);
    tick_run  = (state_reg == RUN) && bus.i_basetick && !bus.i_set_req;
    sec_adv   = tick_run && (presc_reg == PRESC_MAX);
    load_ok   = (state_reg == LOAD) && cap_valid;
    load_bad  = (state_reg == LOAD) && !cap_valid;
  end

  always_comb begin
    inc_ss = (ss_reg == 6'd59) ? 6'd0 : ss_reg + 6'd1;
    inc_mm = mm_reg;
    inc_hh = hh_reg;
    if (ss_reg == 6'd59) begin
      inc_mm = (mm_reg == 6'd59) ? 6'd0 : mm_reg + 6'd1;
      if (mm_reg == 6'd59) inc_hh = (hh_reg == 5'd23) ? 5'd0 : hh_reg + 5'd1;
    end
  end

  // Match is evaluated against the value about to be written, so the irq edge
  // coincides with the time update and an idle clock never re-matches.
  always_comb begin
    presc_next = presc_reg;
    hh_next    = hh_reg;
    mm_next    = mm_reg;
    ss_next    = ss_reg;
    if (load_ok) begin
      presc_next = 8'd0;
      hh_next    = cap_hh_reg;
      mm_next    = cap_mm_reg;
      ss_next    = cap_ss_reg;
    end else if (tick_run) begin
      presc_next = sec_adv ? 8'd0 : presc_reg + 8'd1;
      if (sec_adv) begin
        hh_next = inc_hh;
        mm_next = inc_mm;
        ss_next = inc_ss;
      end
    end
    time_match = bus.i_alarm_en && (sec_adv || load_ok) &&
                 ({hh_next, mm_next, ss_next} == {alm_hh_reg, alm_mm_reg, alm_ss_reg});
  end

  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      presc_reg     <= 8'd0;
      hh_reg        <= 5'd0;
      mm_reg        <= 6'd0;
      ss_reg        <= 6'd0;
      cap_hh_reg    <= 5'd0;
      cap_mm_reg    <= 6'd0;
      cap_ss_reg    <= 6'd0;
      alm_hh_reg    <= 5'd0;
      alm_mm_reg    <= 6'd0;
      alm_ss_reg    <= 6'd0;
      sec_pulse_reg <= 1'b0;
      set_ack_reg   <= 1'b0;
      set_err_reg   <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      presc_reg     <= presc_next;
      hh_reg        <= hh_next;
      mm_reg        <= mm_next;
      ss_reg        <= ss_next;
      if (bus.i_set_req) begin
        cap_hh_reg <= bus.i_set_hh;
        cap_mm_reg <= bus.i_set_mm;
        cap_ss_reg <= bus.i_set_ss;
      end
      if (bus.i_alarm_wr) begin
        alm_hh_reg <= bus.i_alarm_hh;
        alm_mm_reg <= bus.i_alarm_mm;
        alm_ss_reg <= bus.i_alarm_ss;
      end
      sec_pulse_reg <= sec_adv;
      set_ack_reg   <= load_ok;
      set_err_reg   <= load_bad;
      if (time_match)         irq_reg <= 1'b1;
      else if (bus.i_irq_ack) irq_reg <= 1'b0;
    end
  end

  assign bus.o_timerenb  = timerenb;
  assign bus.o_hh        = hh_reg;
  assign bus.o_mm        = mm_reg;
  assign bus.o_ss        = ss_reg;
  assign bus.o_sec_pulse = sec_pulse_reg;
  assign bus.o_set_ack   = set_ack_reg;
  assign bus.o_set_err   = set_err_reg;
  assign bus.o_irq       = irq_reg;

endmodule

// File: tb/tb_rtc_ctrl.sv
// Self-checking bench for rtc_ctrl with TICKS_PER_SEC=4: a transaction model queues
// expected pulse events (kind + time) that a negedge monitor pops and compares.
module tb_rtc_ctrl;
  localparam int TPS = 4;
  localparam logic [1:0] EV_SEC = 2'd1, EV_ACK = 2'd2, EV_ERR = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rtc_ctrl_if bus ();
  rtc_ctrl #(.TICKS_PER_SEC(TPS)) dut (.i_sclk(clk), .i_reset(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  logic [18:0] exp_q[$];
  logic [18:0] ev_obs, ev_exp;
  logic [4:0] m_hh;
  logic [5:0] m_mm, m_ss;
  int m_presc;
  bit running;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_sec_pulse || bus.o_set_ack || bus.o_set_err) begin
      ev_obs = {bus.o_sec_pulse ? EV_SEC : (bus.o_set_ack ? EV_ACK : EV_ERR), bus.o_hh, bus.o_mm, bus.o_ss};
      ev_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 19'd0;
      $display("event kind=%0d time=%0d:%0d:%0d", ev_obs[18:17], bus.o_hh, bus.o_mm, bus.o_ss);
      chk("event", 32'(ev_obs), 32'(ev_exp));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k);
    exp_q.push_back({k, m_hh, m_mm, m_ss});
  endtask

  task automatic model_clear();
    m_hh = 0; m_mm = 0; m_ss = 0; m_presc = 0; running = 0;
  endtask

  task automatic adv();
    if (m_ss == 59) begin
      m_ss = 0;
      if (m_mm == 59) begin
        m_mm = 0;
        m_hh = (m_hh == 23) ? 5'd0 : m_hh + 5'd1;
      end else m_mm = m_mm + 6'd1;
    end else m_ss = m_ss + 6'd1;
  endtask

  task automatic chk_time(input string tag);
    chk(tag, 32'({bus.o_hh, bus.o_mm, bus.o_ss}), 32'({m_hh, m_mm, m_ss}));
  endtask

  task automatic tick(input logic ack);
    bus.i_basetick = 1'b1;
    bus.i_irq_ack  = ack;
    if (running) begin
      m_presc++;
      if (m_presc == TPS) begin
        m_presc = 0;
        adv();
        push(EV_SEC);
      end
    end
    cyc(1);
    bus.i_basetick = 1'b0;
    bus.i_irq_ack  = 1'b0;
    cyc(2);
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    bus.i_set_hh = h; bus.i_set_mm = m; bus.i_set_ss = s;
    bus.i_set_req = 1'b1;
    cyc(1);
    bus.i_set_req = 1'b0;
    chk("timerenb_in_load", 32'(bus.o_timerenb), 32'd0);
    if (h <= 23 && m <= 59 && s <= 59) begin
      m_hh = h; m_mm = m; m_ss = s; m_presc = 0;
      push(EV_ACK);
    end else begin
      push(EV_ERR);
    end
    cyc(3);
    running = bus.i_run;
  endtask

  task automatic set_run(input logic v);
    bus.i_run = v;
    cyc(1);
    running = v;
    chk("timerenb", 32'(bus.o_timerenb), 32'(v));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_time"}, 32'({bus.o_hh, bus.o_mm, bus.o_ss}), 32'd0);
    chk({tag, "_flags"}, 32'({bus.o_timerenb, bus.o_sec_pulse, bus.o_set_ack, bus.o_set_err, bus.o_irq}), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_basetick = 0; bus.i_run = 0; bus.i_set_req = 0; bus.i_alarm_wr = 0;
    bus.i_alarm_en = 0; bus.i_irq_ack = 0;
    cyc(2);
    chk_zero("reset");
    rst = 1'b0;
    model_clear();
    exp_q.delete();
    cyc(1);
  endtask

  initial begin
    bus.i_set_hh = 0; bus.i_set_mm = 0; bus.i_set_ss = 0;
    bus.i_alarm_hh = 0; bus.i_alarm_mm = 0; bus.i_alarm_ss = 0;
    model_clear();
    do_reset();

    // run from reset, one tick every 10 cycles
    set_run(1'b1);
    repeat (4) begin tick(1'b0); cyc(7); end
    chk_time("first_second");

    // midnight rollover in one edge
    set_time(5'd23, 6'd59, 6'd59);
    repeat (4) tick(1'b0);
    chk_time("midnight_wrap");

    // invalid loads keep time and prescaler
    repeat (2) tick(1'b0);
    set_time(5'd24, 6'd0, 6'd0);
    chk_time("bad_hh_unchanged");
    set_time(5'd12, 6'd60, 6'd0);
    chk_time("bad_mm_unchanged");
    repeat (2) tick(1'b0);
    chk_time("presc_kept_after_err");

    // alarm set, ack, and set-beats-ack
    do_reset();
    bus.i_alarm_hh = 0; bus.i_alarm_mm = 0; bus.i_alarm_ss = 6'd2;
    bus.i_alarm_wr = 1'b1;
    cyc(1);
    bus.i_alarm_wr = 1'b0;
    bus.i_alarm_en = 1'b1;
    set_run(1'b1);
    repeat (7) tick(1'b0);
    chk("irq_before_match", 32'(bus.o_irq), 32'd0);
    tick(1'b0);
    chk("irq_on_match", 32'(bus.o_irq), 32'd1);
    chk_time("match_time");
    bus.i_irq_ack = 1'b1;
    cyc(1);
    bus.i_irq_ack = 1'b0;
    chk("irq_acked", 32'(bus.o_irq), 32'd0);
    set_time(5'd0, 6'd0, 6'd1);
    chk("irq_no_match_load", 32'(bus.o_irq), 32'd0);
    repeat (3) tick(1'b0);
    tick(1'b1);
    chk("irq_set_beats_ack", 32'(bus.o_irq), 32'd1);
    set_run(1'b0);
    bus.i_irq_ack = 1'b1;
    cyc(1);
    bus.i_irq_ack = 1'b0;
    cyc(5);
    chk("irq_no_rematch_stopped", 32'(bus.o_irq), 32'd0);
    set_time(5'd0, 6'd0, 6'd2);
    chk("irq_on_load_match", 32'(bus.o_irq), 32'd1);
    bus.i_alarm_en = 1'b0;

    // prescaler holds while stopped
    do_reset();
    set_run(1'b1);
    repeat (2) tick(1'b0);
    set_run(1'b0);
    repeat (5) tick(1'b0);
    set_run(1'b1);
    repeat (2) tick(1'b0);
    chk_time("one_second_across_stop");

    // reset during LOAD, then alarm registers must read as cleared
    do_reset();
    bus.i_alarm_hh = 5'd5; bus.i_alarm_mm = 6'd5; bus.i_alarm_ss = 6'd5;
    bus.i_alarm_wr = 1'b1;
    cyc(1);
    bus.i_alarm_wr = 1'b0;
    bus.i_set_hh = 5'd12; bus.i_set_mm = 6'd34; bus.i_set_ss = 6'd56;
    bus.i_set_req = 1'b1;
    cyc(1);
    bus.i_set_req = 1'b0;
    rst = 1'b1;
    cyc(1);
    chk_zero("rst_in_load");
    rst = 1'b0;
    model_clear();
    cyc(2);
    chk_zero("after_rst_in_load");
    bus.i_alarm_en = 1'b1;
    set_time(5'd0, 6'd0, 6'd0);
    chk("alarm_cleared_by_reset", 32'(bus.o_irq), 32'd1);
    bus.i_alarm_en = 1'b0;

    // reset on the edge of a 00:59:59 carry
    do_reset();
    set_run(1'b1);
    set_time(5'd0, 6'd59, 6'd59);
    repeat (3) tick(1'b0);
    bus.i_basetick = 1'b1;
    rst = 1'b1;
    cyc(1);
    bus.i_basetick = 1'b0;
    chk_zero("rst_at_carry");
    rst = 1'b0;
    model_clear();
    cyc(1);
    running = 1'b1;
    chk("resume_run", 32'(bus.o_timerenb), 32'd1);
    chk_time("time_after_carry_rst");
    cyc(2);

    chk("events_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
